// File: rtl/sweep_segment_packer.sv
// Packs seven 32-bit host words into one 196-bit sweep entry and writes the entry to the sweep FIFO.
// Can issue an optional start pulse at program end; an entry is dropped (and flagged) once MAX_ENTRIES is reached.
module sweep_segment_packer #(
  parameter int WORDS_PER_ENTRY = 7,
  parameter int MAX_ENTRIES     = 1024
) (
  input  logic         clk_50,
  input  logic         reset,
  input  logic [31:0]  host_data,
  input  logic         host_valid,
  input  logic         host_last,
  output logic         host_ready,
  input  logic         clear_cmd,
  input  logic         autostart,
  input  logic         running,
  output logic         fifo_wr_req,
  output logic [195:0] fifo_wr_data,
  input  logic         fifo_wr_full,
  output logic         start_fifo_cmd,
  output logic [15:0]  entry_count,
  output logic         err_short,
  output logic         err_overflow,
  output logic         busy
);

  localparam logic [2:0]  LAST_IDX = 3'(WORDS_PER_ENTRY - 1);
  localparam logic [15:0] MAX_CNT  = 16'(MAX_ENTRIES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_START
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     widx_q, widx_d;
  logic [195:0]   entry_q, entry_d;
  logic           wr_req_q, wr_req_d;
  logic           start_q, start_d;
  logic [15:0]    count_q, count_d;
  logic           err_short_q, err_short_d;
  logic           err_ovf_q, err_ovf_d;
  logic           last_q, last_d;
  logic           done_q, done_d;
  logic           accept;

  assign host_ready = !reset && !running && !clear_cmd &&
                      ((state_q == ST_IDLE) || (state_q == ST_COLLECT));
  assign accept     = host_valid && host_ready;

  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    entry_d     = entry_q;
    wr_req_d    = 1'b0;
    start_d     = 1'b0;
    count_d     = count_q;
    err_short_d = err_short_q;
    err_ovf_d   = err_ovf_q;
    last_d      = last_q;
    done_d      = done_q;

    if (clear_cmd) begin
      state_d     = ST_IDLE;
      widx_d      = 3'd0;
      count_d     = 16'd0;
      err_short_d = 1'b0;
      err_ovf_d   = 1'b0;
      last_d      = 1'b0;
      done_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_COLLECT: begin
          if (accept) begin
            case (widx_q)
              3'd0:    entry_d[31:0]    = host_data;
              3'd1:    entry_d[63:32]   = host_data;
              3'd2:    entry_d[95:64]   = host_data;
              3'd3:    entry_d[127:96]  = host_data;
              3'd4:    entry_d[159:128] = host_data;
              3'd5:    entry_d[191:160] = host_data;
              3'd6:    entry_d[195:192] = host_data[3:0];
              default: entry_d          = entry_q;
            endcase

            // widx is always 0 in IDLE, so only COLLECT can complete an entry
            if (widx_q == LAST_IDX) begin
              widx_d  = 3'd0;
              last_d  = host_last;
              state_d = ST_WRITE;
              if (count_q == MAX_CNT) begin
                err_ovf_d = 1'b1;
                done_d    = 1'b1;
              end else if (!fifo_wr_full) begin
                wr_req_d = 1'b1;
                count_d  = count_q + 16'd1;
                done_d   = 1'b1;
              end else begin
                done_d = 1'b0;
              end
            end else if (host_last) begin
              widx_d      = 3'd0;
              err_short_d = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              widx_d  = widx_q + 3'd1;
              state_d = ST_COLLECT;
            end
          end
        end

        ST_WRITE: begin
          // done_q means the entry was either strobed out this cycle or dropped
          if (done_q) begin
            done_d = 1'b0;
            if (last_q && autostart) begin
              state_d = ST_START;
              start_d = !running && (count_q != 16'd0);
            end else begin
              state_d = ST_IDLE;
            end
          end else if (!fifo_wr_full) begin
            wr_req_d = 1'b1;
            count_d  = count_q + 16'd1;
            done_d   = 1'b1;
          end
        end

        ST_START: begin
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      widx_q      <= 3'd0;
      entry_q     <= '0;
      wr_req_q    <= 1'b0;
      start_q     <= 1'b0;
      count_q     <= 16'd0;
      err_short_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      entry_q     <= entry_d;
      wr_req_q    <= wr_req_d;
      start_q     <= start_d;
      count_q     <= count_d;
      err_short_q <= err_short_d;
      err_ovf_q   <= err_ovf_d;
      last_q      <= last_d;
      done_q      <= done_d;
    end
  end

  assign fifo_wr_req    = wr_req_q;
  assign fifo_wr_data   = entry_q;
  assign start_fifo_cmd = start_q;
  assign entry_count    = count_q;
  assign err_short      = err_short_q;
  assign err_overflow   = err_ovf_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sweep_segment_packer.sv
// Bench for sweep_segment_packer, built with MAX_ENTRIES = 4 so that saturation is reachable.
// A transaction-level model predicts FIFO entries, counters, flags and start pulses.
module tb_sweep_segment_packer;

  localparam int MAXE = 4;

  logic         clk_50 = 1'b0;
  logic         reset;
  logic [31:0]  host_data;
  logic         host_valid;
  logic         host_last;
  logic         host_ready;
  logic         clear_cmd;
  logic         autostart;
  logic         running;
  logic         fifo_wr_req;
  logic [195:0] fifo_wr_data;
  logic         fifo_wr_full;
  logic         start_fifo_cmd;
  logic [15:0]  entry_count;
  logic         err_short;
  logic         err_overflow;
  logic         busy;

  sweep_segment_packer #(.WORDS_PER_ENTRY(7), .MAX_ENTRIES(MAXE)) dut (
    .clk_50(clk_50), .reset(reset), .host_data(host_data), .host_valid(host_valid),
    .host_last(host_last), .host_ready(host_ready), .clear_cmd(clear_cmd),
    .autostart(autostart), .running(running), .fifo_wr_req(fifo_wr_req),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_full(fifo_wr_full),
    .start_fifo_cmd(start_fifo_cmd), .entry_count(entry_count), .err_short(err_short),
    .err_overflow(err_overflow), .busy(busy)
  );

  always #10 clk_50 = ~clk_50;

  int tests = 0;
  int fails = 0;

  // model state
  logic [195:0] exp_q[$];
  logic [31:0]  cur_words[7];
  bit           cur_last;
  bit           cur_start_ok;
  int           m_count = 0;
  int           m_starts = 0;
  int           seen_starts = 0;
  bit           m_err_short = 0;
  bit           m_err_ovf = 0;

  task automatic chk(input string nm, input logic [195:0] act, input logic [195:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Called just before the 7th word is accepted.
  task automatic model_final();
    logic [195:0] e;
    e = {cur_words[6][3:0], cur_words[5], cur_words[4], cur_words[3],
         cur_words[2], cur_words[1], cur_words[0]};
    if (m_count < MAXE) begin
      exp_q.push_back(e);
      m_count++;
    end else begin
      m_err_ovf = 1;
    end
    if (cur_last && autostart && cur_start_ok && m_count > 0) m_starts++;
  endtask

  task automatic model_zero();
    exp_q.delete();
    m_count     = 0;
    m_err_short = 0;
    m_err_ovf   = 0;
  endtask

  // Starts and ends at a falling edge.
  task automatic send_word(input logic [31:0] d, input bit last, input bit fin);
    bit ok = 0;
    int n = 0;
    host_data  = d;
    host_valid = 1'b1;
    host_last  = last;
    while (!ok && n < 200) begin
      #1;
      ok = host_ready;
      if (ok && fin) model_final();
      @(posedge clk_50);
      @(negedge clk_50);
      n++;
    end
    host_valid = 1'b0;
    host_last  = 1'b0;
    if (!ok) chk("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_range(input int from, input int to, input bit last_at_end);
    cur_last = last_at_end;
    for (int i = from; i < to; i++)
      send_word(cur_words[i], last_at_end && (i == to - 1), i == 6);
    if (last_at_end && to < 7) m_err_short = 1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 7; i++) cur_words[i] = $urandom;
  endtask

  task automatic settle(input string tag);
    repeat (4) @(negedge clk_50);
    chk({tag, "_count"}, entry_count, m_count);
    chk({tag, "_err_short"}, err_short, m_err_short);
    chk({tag, "_err_ovf"}, err_overflow, m_err_ovf);
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_starts"}, seen_starts, m_starts);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // Compare process: sampled 1 ns after each rising edge.
  always begin
    logic [195:0] e;
    @(posedge clk_50);
    #1;
    if (fifo_wr_req === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_data", fifo_wr_data, e);
      end
      chk("wr_count", entry_count, m_count);
    end
    if (start_fifo_cmd === 1'b1) seen_starts++;
    if (fifo_wr_req === 1'b1 || start_fifo_cmd === 1'b1)
      chk("req_start_excl", fifo_wr_req & start_fifo_cmd, 1'b0);
  end

  initial begin
    reset = 1'b1; host_data = '0; host_valid = 0; host_last = 0; clear_cmd = 0;
    autostart = 0; running = 0; fifo_wr_full = 0; cur_last = 0; cur_start_ok = 1;

    // reset values
    repeat (2) @(negedge clk_50);
    chk("rst_wr_req", fifo_wr_req, 1'b0);
    chk("rst_wr_data", fifo_wr_data, '0);
    chk("rst_start", start_fifo_cmd, 1'b0);
    chk("rst_count", entry_count, 16'd0);
    chk("rst_err_short", err_short, 1'b0);
    chk("rst_err_ovf", err_overflow, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    @(negedge clk_50);
    chk("rst_ready", host_ready, 1'b1);

    // basic entry with autostart
    autostart = 1'b1;
    for (int i = 0; i < 7; i++) cur_words[i] = 32'h11111111 * (i + 1);
    send_range(0, 7, 1'b1);
    chk("lat_wr_req", fifo_wr_req, 1'b1);
    chk("lit_freq_init", fifo_wr_data[31:0], 32'h11111111);
    chk("lit_dem_delay", fifo_wr_data[191:176], 16'h6666);
    chk("lit_flags", fifo_wr_data[195:192], 4'h7);
    chk("lit_count", entry_count, 16'd1);
    chk("lit_no_start_yet", start_fifo_cmd, 1'b0);
    @(negedge clk_50);
    chk("lit_start", start_fifo_cmd, 1'b1);
    chk("lit_wr_done", fifo_wr_req, 1'b0);
    settle("basic");

    // short program, then a normal entry
    autostart = 1'b0;
    fill_random();
    send_range(0, 4, 1'b1);
    chk("short_flag", err_short, 1'b1);
    settle("short");
    fill_random();
    send_range(0, 7, 1'b0);
    settle("after_short");

    // FIFO full during WRITE
    fifo_wr_full = 1'b1;
    fill_random();
    send_range(0, 7, 1'b0);
    for (int k = 0; k < 10; k++) begin
      chk("full_no_req", fifo_wr_req, 1'b0);
      chk("full_ready", host_ready, 1'b0);
      chk("full_data", fifo_wr_data, exp_q[0]);
      @(negedge clk_50);
    end
    fifo_wr_full = 1'b0;
    @(negedge clk_50);
    chk("full_release_req", fifo_wr_req, 1'b1);
    settle("full");

    // overflow at MAX_ENTRIES
    clear_cmd = 1'b1;
    @(negedge clk_50);
    clear_cmd = 1'b0;
    model_zero();
    for (int n = 0; n < 5; n++) begin
      fill_random();
      send_range(0, 7, 1'b0);
    end
    settle("ovf");
    chk("ovf_count_lit", entry_count, 16'd4);

    // clear coincident with the 7th word
    fill_random();
    send_range(0, 2, 1'b1);
    fill_random();
    for (int i = 0; i < 6; i++) send_word(cur_words[i], 1'b0, 1'b0);
    host_data = cur_words[6]; host_valid = 1'b1; host_last = 1'b1; clear_cmd = 1'b1;
    #1;
    chk("clr_ready", host_ready, 1'b0);
    @(negedge clk_50);
    host_valid = 1'b0; host_last = 1'b0; clear_cmd = 1'b0;
    model_zero();
    chk("clr_no_req", fifo_wr_req, 1'b0);
    settle("clear");

    // running pauses collection and suppresses the start pulse
    autostart = 1'b1;
    fill_random();
    send_range(0, 7, 1'b0);
    fill_random();
    send_range(0, 3, 1'b0);
    running = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("run_ready", host_ready, 1'b0);
      chk("run_busy", busy, 1'b1);
      @(negedge clk_50);
    end
    running = 1'b0;
    cur_start_ok = 1'b0;
    send_range(3, 7, 1'b1);
    running = 1'b1;
    repeat (3) @(negedge clk_50);
    running = 1'b0;
    cur_start_ok = 1'b1;
    settle("running");

    // reset with a write pending
    fifo_wr_full = 1'b1;
    fill_random();
    send_range(0, 7, 1'b0);
    reset = 1'b1;
    @(negedge clk_50);
    chk("rst_mid_req", fifo_wr_req, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_count", entry_count, 16'd0);
    model_zero();
    fifo_wr_full = 1'b0;
    reset = 1'b0;
    @(negedge clk_50);
    chk("rst_mid_ready", host_ready, 1'b1);
    settle("rst_mid");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sweep_segment_packer.md
SWEEP_SEGMENT_PACKER -- requirements
Module: sweep_segment_packer

Interface
REQ-001 Parameter WORDS_PER_ENTRY, 7, number of 32-bit host words per 196-bit sweep entry; fixed value, other values unsupported.
REQ-002 Parameter MAX_ENTRIES, 1024, entries accepted between clears; equals downstream FIFO depth.
REQ-003 clk_50  in  1  system clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 host_data  in  32  host word.
REQ-006 host_valid  in  1  host word present.
REQ-007 host_last  in  1  qualifies host_valid; marks final word of a sweep program.
REQ-008 host_ready  out  1  word accepted when host_valid && host_ready.
REQ-009 clear_cmd  in  1  single-cycle pulse; abort partial entry, zero counters and flags.
REQ-010 autostart  in  1  level; enables start pulse after program end.
REQ-011 running  in  1  sweep/step controller active.
REQ-012 fifo_wr_req  out  1  single-cycle write strobe to sweep FIFO.
REQ-013 fifo_wr_data  out  196  packed entry; valid while fifo_wr_req high.
REQ-014 fifo_wr_full  in  1  FIFO full.
REQ-015 start_fifo_cmd  out  1  single-cycle pulse to sweep controller.
REQ-016 entry_count  out  16  entries written since last clear/reset.
REQ-017 err_short  out  1  sticky; program ended mid-entry.
REQ-018 err_overflow  out  1  sticky; entry dropped at MAX_ENTRIES.
REQ-019 busy  out  1  high in any state except IDLE.

Function
REQ-020 States: IDLE, COLLECT, WRITE, START; word index widx 0..6.
REQ-021 host_ready = 1 in IDLE/COLLECT when running = 0 and clear_cmd = 0; else 0.
REQ-022 Packing: word0 -> [31:0] freq_initial; word1 -> [63:32] freq_final; word2 -> [95:64] freq_step LSW; word3 -> [127:96] freq_step MSW; word4 -> [159:128] step_counter; word5[15:0] -> [175:160] wfm_amplitude, word5[31:16] -> [191:176] dem_delay; word6[3:0] -> [195:192] flags, word6[31:4] discarded.
REQ-023 IDLE: accepted word stored as word0, widx <= 1, -> COLLECT.
REQ-024 COLLECT: each accepted word stored at widx, widx increments; 7th word (widx = 6) -> WRITE, widx <= 0; host_last latched with it.
REQ-025 host_last accepted with widx != 6: partial entry discarded, err_short <= 1, widx <= 0, -> IDLE; no FIFO write.
REQ-026 WRITE: if fifo_wr_full = 0, fifo_wr_req = 1 for exactly one cycle, entry_count increments; latency one cycle after 7th word accepted when not full.
REQ-027 WRITE with fifo_wr_full = 1: hold, host_ready = 0, fifo_wr_data stable until write issued.
REQ-028 WRITE with entry_count = MAX_ENTRIES: no write, err_overflow <= 1, entry_count unchanged, entry dropped.
REQ-029 After WRITE (written or dropped): latched host_last = 1 and autostart = 1 -> START; else -> IDLE.
REQ-030 START: start_fifo_cmd = 1 for one cycle only if running = 0 and at least one entry written since clear; then -> IDLE.
REQ-031 entry_count saturates at MAX_ENTRIES; never wraps.
REQ-032 clear_cmd has priority over every other event in the same cycle: -> IDLE, widx, entry_count, err_short, err_overflow <= 0, no write, no start pulse.
REQ-033 running rising mid-COLLECT: collection pauses (host_ready = 0) and resumes without loss when running falls.
REQ-034 fifo_wr_req and start_fifo_cmd never high in the same cycle.

Reset
REQ-035 reset: state IDLE, widx 0, fifo_wr_req 0, fifo_wr_data 0, start_fifo_cmd 0, entry_count 0, err_short 0, err_overflow 0, busy 0; host_ready 1 the cycle after reset falls (running = 0).
REQ-036 reset mid-operation discards partial entry and any pending write; no strobe issued in the reset cycle.

Verification
REQ-037 7 words 0x11111111..0x77777777, host_last on 7th, autostart = 1, full = 0 -> one fifo_wr_req with [31:0] = 0x11111111, [191:176] = 0x6666, [195:192] = 0x7; entry_count = 1; start_fifo_cmd one cycle later.
REQ-038 host_last on 4th word -> err_short = 1, no fifo_wr_req, state IDLE; next 7-word entry writes normally.
REQ-039 fifo_wr_full held 10 cycles at WRITE -> host_ready 0, data stable, single write when full falls.
REQ-040 MAX_ENTRIES = 4 build, 5 entries -> 4 writes, err_overflow = 1, entry_count = 4.
REQ-041 clear_cmd coincident with 7th word -> no write, counters/flags 0, IDLE.
REQ-042 running = 1 during entry 2 -> host_ready 0, no start pulse; released -> entry completes, contents correct.
